// File: rtl/bist_pkg.sv
// Shared BIST types and helpers: sweep ordering modes, sequencer states, Gray encoding.
package bist_pkg;

    typedef enum logic [1:0] {
        LINEAR = 2'd0,
        GRAY   = 2'd1,
        COMPL  = 2'd2,
        RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bist_range_cnt.sv
// Loadable up/down counter that walks from a start bound to an end bound and then holds,
// flagging the terminal value. Never wraps: the end compare stops it before overflow.
module bist_range_cnt #(
    parameter int ADR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dir,
    input  logic [ADR_W-1:0] lo,
    input  logic [ADR_W-1:0] hi,
    input  logic             en,
    output logic [ADR_W-1:0] cnt,
    output logic             term
);

    logic [ADR_W-1:0] end_val;
    logic             dir_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            end_val <= '0;
            dir_r   <= 1'b0;
        end else if (load) begin
            cnt     <= dir ? lo : hi;
            end_val <= dir ? hi : lo;
            dir_r   <= dir;
        end else if (en && !term) begin
            cnt <= dir_r ? cnt + 1'b1 : cnt - 1'b1;
        end
    end

    assign term = (cnt == end_val);

endmodule

// File: rtl/bist_march_adr_seq.sv
// BIST march address sequencer: linear, Gray or complement-pair sweeps over a programmable
// range with start/abort/done handshake. One instance per memory port.
module bist_march_adr_seq
    import bist_pkg::*;
#(
    parameter int ADR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [ADR_W-1:0] lo_adr,
    input  logic [ADR_W-1:0] hi_adr,
    input  logic             step,
    output logic [ADR_W-1:0] adr,
    output logic             adr_vld,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;
    localparam logic [ADR_W-1:0] HALF_MAX = {1'b0, {(ADR_W-1){1'b1}}};

    logic [1:0]       state;
    logic [1:0]       mode_r;
    logic             ph;
    logic             is_compl;
    logic             cfg_bad;
    logic             accept;
    logic             run_step;
    logic             cnt_en;
    logic             term;
    logic [ADR_W-1:0] cnt;
    logic [ADR_W-1:0] cnt_lo;
    logic [ADR_W-1:0] cnt_hi;

    assign is_compl = (mode_r == COMPL);
    assign cfg_bad  = (mode != COMPL) && (lo_adr > hi_adr);
    assign accept   = (state == ST_IDLE) && start && !cfg_bad;
    assign run_step = (state == ST_RUN) && step && !abort;

    // Complement order reuses the range counter as the half-counter over the lower half
    assign cnt_lo = (mode == COMPL) ? '0 : lo_adr;
    assign cnt_hi = (mode == COMPL) ? HALF_MAX : hi_adr;
    assign cnt_en = run_step && (!is_compl || ph);

    bist_range_cnt #(.ADR_W(ADR_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .dir  (dir),
        .lo   (cnt_lo),
        .hi   (cnt_hi),
        .en   (cnt_en),
        .cnt  (cnt),
        .term (term)
    );

    assign busy    = (state == ST_RUN);
    assign adr_vld = busy;
    assign done    = (state == ST_DONE);
    assign last    = busy && term && (!is_compl || ph);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mode_r  <= LINEAR;
            ph      <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state == ST_IDLE) && start && cfg_bad;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_RUN;
                        mode_r <= mode;
                        ph     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (step && last) begin
                        state <= ST_DONE;
                    end else if (step && is_compl) begin
                        ph <= ~ph;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output mapping holds its last value outside RUN because cnt and ph are frozen there
    always_comb begin
        case (mode_r)
            GRAY:    adr = ADR_W'(bin2gray(32'(cnt)));
            COMPL:   adr = ph ? ~cnt : cnt;
            default: adr = cnt;
        endcase
    end

endmodule

// File: tb/tb_bist_march_adr_seq.sv
// Scoreboard bench for bist_march_adr_seq (ADR_W=4): expected sweeps are queued at start
// and popped as the sequencer steps through them.
module tb_bist_march_adr_seq;

    logic       clk = 1'b0;
    logic       rst, start, abort, dir, step;
    logic [1:0] mode;
    logic [3:0] lo_adr, hi_adr;
    logic [3:0] adr;
    logic       adr_vld, last, busy, done, cfg_err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    bist_march_adr_seq #(.ADR_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .dir     (dir),
        .mode    (mode),
        .lo_adr  (lo_adr),
        .hi_adr  (hi_adr),
        .step    (step),
        .adr     (adr),
        .adr_vld (adr_vld),
        .last    (last),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".adr"}, adr, 0);
        check({tag, ".adr_vld"}, adr_vld, 0);
        check({tag, ".last"}, last, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".cfg_err"}, cfg_err, 0);
    endtask

    task automatic push_expected(input logic [1:0] m, input logic d, input logic [3:0] l,
                                 input logic [3:0] h);
        int lo_i, hi_i, hv;
        exp_q.delete();
        lo_i = int'(l);
        hi_i = int'(h);
        if (m == 2'd2) begin
            for (int i = 0; i < 8; i++) begin
                hv = d ? i : 7 - i;
                exp_q.push_back(4'(hv));
                exp_q.push_back(4'(15 - hv));
            end
        end else if (d) begin
            for (int v = lo_i; v <= hi_i; v++)
                exp_q.push_back((m == 2'd1) ? 4'(v ^ (v >> 1)) : 4'(v));
        end else begin
            for (int v = hi_i; v >= lo_i; v--)
                exp_q.push_back((m == 2'd1) ? 4'(v ^ (v >> 1)) : 4'(v));
        end
    endtask

    // Runs one sweep; step every `period` cycles; abort_at >= 0 aborts on that address index.
    task automatic sweep(input string name, input logic [1:0] m, input logic d,
                         input logic [3:0] l, input logic [3:0] h,
                         input int period, input int abort_at);
        logic [3:0] held;
        int  popped;
        bit  fin;
        bit  s;
        popped = 0;
        fin    = 1'b0;
        push_expected(m, d, l, h);
        @(negedge clk);
        start = 1'b1; mode = m; dir = d; lo_adr = l; hi_adr = h; step = 1'b0; abort = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 200 && !fin; c++) begin
            check({name, ".busy"}, busy, 1);
            check({name, ".adr_vld"}, adr_vld, 1);
            check({name, ".cfg_err"}, cfg_err, 0);
            check({name, ".adr"}, adr, exp_q[0]);
            check({name, ".last"}, last, exp_q.size() == 1);
            // Mid-sweep start with changed (and invalid) config must be ignored
            start = (c == 0);
            if (c == 0) begin
                mode = ~m; dir = ~d; lo_adr = 4'd9; hi_adr = 4'd3;
            end
            if (abort_at >= 0 && popped == abort_at) begin
                abort = 1'b1; step = 1'b1; held = exp_q[0];
                @(negedge clk);
                abort = 1'b0; step = 1'b0;
                check({name, ".abort_busy"}, busy, 0);
                check({name, ".abort_done"}, done, 0);
                check({name, ".abort_adr"}, adr, held);
                @(negedge clk);
                check({name, ".abort_done2"}, done, 0);
                fin = 1'b1;
            end else begin
                s = ((c % period) == (period - 1));
                step = s;
                if (s) begin
                    held = exp_q.pop_front();
                    popped++;
                end
                @(negedge clk);
                if (s && exp_q.size() == 0) begin
                    step = 1'b0;
                    check({name, ".done"}, done, 1);
                    check({name, ".done_busy"}, busy, 0);
                    check({name, ".done_last"}, last, 0);
                    check({name, ".done_adr"}, adr, held);
                    start = 1'b1; mode = m; dir = d; lo_adr = l; hi_adr = h;
                    @(negedge clk);
                    start = 1'b0;
                    check({name, ".post_done"}, done, 0);
                    check({name, ".start_in_done"}, busy, 0);
                    fin = 1'b1;
                end
            end
        end
        if (!fin) check({name, ".timeout"}, 0, 1);
        start = 1'b0; step = 1'b0; abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b1; step = 1'b0;
        mode = 2'd0; lo_adr = 4'd0; hi_adr = 4'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        sweep("lin_up",    2'd0, 1'b1, 4'd2, 4'd5,  1, -1);
        sweep("lin_dn",    2'd0, 1'b0, 4'd0, 4'd15, 3, -1);
        sweep("lin_full",  2'd0, 1'b1, 4'd0, 4'd15, 2, -1);
        sweep("gray_up",   2'd1, 1'b1, 4'd0, 4'd3,  1, -1);
        sweep("gray_dn",   2'd1, 1'b0, 4'd0, 4'd3,  1, -1);
        sweep("compl_up",  2'd2, 1'b1, 4'd0, 4'd0,  1, -1);
        sweep("compl_dn",  2'd2, 1'b0, 4'd0, 4'd0,  2, -1);
        sweep("rsvd_up",   2'd3, 1'b1, 4'd4, 4'd7,  1, -1);
        sweep("single",    2'd0, 1'b1, 4'd6, 4'd6,  1, -1);

        @(negedge clk);
        start = 1'b1; mode = 2'd0; dir = 1'b1; lo_adr = 4'd9; hi_adr = 4'd3;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err.pulse", cfg_err, 1);
        check("cfg_err.busy", busy, 0);
        @(negedge clk);
        check("cfg_err.clear", cfg_err, 0);
        check("cfg_err.busy2", busy, 0);

        sweep("abort", 2'd0, 1'b1, 4'd1, 4'd8, 1, 2);
        sweep("abort_compl", 2'd2, 1'b0, 4'd0, 4'd0, 1, 5);

        @(negedge clk);
        start = 1'b1; mode = 2'd2; dir = 1'b1; lo_adr = 4'd0; hi_adr = 4'd0;
        @(negedge clk);
        start = 1'b0; step = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst.busy", busy, 1);
        rst = 1'b1; step = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        rst = 1'b0;

        sweep("after_rst", 2'd1, 1'b1, 4'd4, 4'd7, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
